// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// One transaction is outstanding at a time, against a fixed memory read latency.
module unified_mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [3:0]       d_byteen,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_data_in,
  output logic [3:0]       mem_byteen,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [WIDTH-1:0] mem_data_out
);

  localparam logic [2:0] LAT        = 3'(MEM_LATENCY);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

  state_e     state_q;
  owner_e     owner_q;
  logic [2:0] cnt_q;
  logic [3:0] starve_q, starve_d;
  logic       isWrite_q;

  logic respCycle, issueCapable, ifWins, dWins, ifGnt, dGnt;

  // Gating with rst_n keeps grants and strobes low for the whole reset interval.
  assign respCycle    = (state_q == BUSY) && (cnt_q == LAT);
  assign issueCapable = rst_n && ((state_q == IDLE) || respCycle);
  assign ifWins       = if_req && (!d_req || (starve_q >= STARVE_MAX));
  assign dWins        = d_req && !ifWins;
  assign ifGnt        = issueCapable && ifWins;
  assign dGnt         = issueCapable && dWins;
  assign if_gnt       = ifGnt;
  assign d_gnt        = dGnt;

  assign if_rvalid = respCycle && (owner_q == OWN_IF);
  assign d_rvalid  = respCycle && (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_data_out : '0;
  assign d_rdata   = (d_rvalid && !isWrite_q) ? mem_data_out : '0;

  always_comb begin
    mem_addr    = '0;
    mem_data_in = '0;
    mem_byteen  = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    if (ifGnt) begin
      mem_addr   = if_addr;
      mem_byteen = 4'b1111;
      mem_read   = 1'b1;
    end else if (dGnt) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_write   = 1'b1;
        mem_data_in = d_wdata;
        mem_byteen  = d_byteen;
      end else begin
        mem_read   = 1'b1;
        mem_byteen = 4'b1111;
      end
    end
  end

  // Only a contention lost by fetch counts toward starvation.
  always_comb begin
    starve_d = starve_q;
    if (ifGnt) begin
      starve_d = '0;
    end else if (dGnt && if_req) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      cnt_q     <= '0;
      starve_q  <= '0;
      isWrite_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      if ((state_q == IDLE) || respCycle) begin
        if (ifGnt || dGnt) begin
          state_q   <= BUSY;
          cnt_q     <= 3'd1;
          owner_q   <= ifGnt ? OWN_IF : OWN_D;
          isWrite_q <= dGnt && d_we;
        end else begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          owner_q   <= OWN_NONE;
          isWrite_q <= 1'b0;
        end
      end else begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: instance A has latency 1, instance B has latency 3, and both share clock and reset.
// Stimulus queues cycle-stamped expectations, and a negedge monitor matches them against DUT output.
module tb_unified_mem_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]   ifReq, dReq, dWe, ifGnt, dGnt, ifRvalid, dRvalid, memRead, memWrite;
  logic [W-1:0] ifAddr[2], dAddr[2], dWdata[2], ifRdata[2], dRdata[2];
  logic [W-1:0] memAddr[2], memDataIn[2], memDataOut[2];
  logic [3:0]   dByteen[2], memByteen[2];
  logic [W-1:0] pipe[2][3];

  typedef struct {
    int          dut;
    int          cyc;
    bit          isIf;
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    logic [31:0] din;
    logic [3:0]  be;
  } iss_t;

  typedef struct {
    int          dut;
    int          cyc;
    bit          isIf;
    logic [31:0] data;
  } rsp_t;

  iss_t issQ[$];
  rsp_t rspQ[$];

  unified_mem_arbiter #(.WIDTH(W), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dutA (
    .clk(clk), .rst_n(rst_n),
    .if_req(ifReq[0]), .if_addr(ifAddr[0]), .if_gnt(ifGnt[0]),
    .if_rvalid(ifRvalid[0]), .if_rdata(ifRdata[0]),
    .d_req(dReq[0]), .d_we(dWe[0]), .d_addr(dAddr[0]), .d_wdata(dWdata[0]),
    .d_byteen(dByteen[0]), .d_gnt(dGnt[0]), .d_rvalid(dRvalid[0]), .d_rdata(dRdata[0]),
    .mem_addr(memAddr[0]), .mem_data_in(memDataIn[0]), .mem_byteen(memByteen[0]),
    .mem_read(memRead[0]), .mem_write(memWrite[0]), .mem_data_out(memDataOut[0])
  );

  unified_mem_arbiter #(.WIDTH(W), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dutB (
    .clk(clk), .rst_n(rst_n),
    .if_req(ifReq[1]), .if_addr(ifAddr[1]), .if_gnt(ifGnt[1]),
    .if_rvalid(ifRvalid[1]), .if_rdata(ifRdata[1]),
    .d_req(dReq[1]), .d_we(dWe[1]), .d_addr(dAddr[1]), .d_wdata(dWdata[1]),
    .d_byteen(dByteen[1]), .d_gnt(dGnt[1]), .d_rvalid(dRvalid[1]), .d_rdata(dRdata[1]),
    .mem_addr(memAddr[1]), .mem_data_in(memDataIn[1]), .mem_byteen(memByteen[1]),
    .mem_read(memRead[1]), .mem_write(memWrite[1]), .mem_data_out(memDataOut[1])
  );

  // Memory content: 0x100 holds a NOP, and every other word is its address XOR 0xA5A50000.
  function automatic logic [31:0] memFn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
  endfunction

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      pipe[s][0] <= memAddr[s];
      pipe[s][1] <= pipe[s][0];
      pipe[s][2] <= pipe[s][1];
    end
  end
  assign memDataOut[0] = memFn(pipe[0][0]);
  assign memDataOut[1] = memFn(pipe[1][2]);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s (cycle %0d): got event, expected none or got none, expected event", name, cyc);
  endtask

  task automatic checkAllZero(input int s, input string what);
    string tag = (s == 0) ? "A" : "B";
    checkOutput({tag, " ", what, " ctrl"},
                {ifGnt[s], dGnt[s], ifRvalid[s], dRvalid[s], memRead[s], memWrite[s], memByteen[s]}, '0);
    checkOutput({tag, " ", what, " buses"},
                {ifRdata[s] | dRdata[s], memAddr[s] | memDataIn[s]}, '0);
  endtask

  task automatic monitorDut(input int s);
    string tag = (s == 0) ? "A" : "B";
    int    i;
    int    idx;
    iss_t  e;
    rsp_t  r;
    i = 0;
    while (i < issQ.size()) begin
      if (issQ[i].dut == s && issQ[i].cyc < cyc) begin
        reportFail({tag, " missing issue"});
        issQ.delete(i);
      end else i++;
    end
    i = 0;
    while (i < rspQ.size()) begin
      if (rspQ[i].dut == s && rspQ[i].cyc < cyc) begin
        reportFail({tag, " missing response"});
        rspQ.delete(i);
      end else i++;
    end

    if (ifGnt[s] || dGnt[s]) begin
      idx = -1;
      foreach (issQ[k]) if (idx < 0 && issQ[k].dut == s && issQ[k].cyc == cyc) idx = k;
      if (idx < 0) begin
        reportFail({tag, " unexpected issue"});
      end else begin
        e = issQ[idx];
        issQ.delete(idx);
        checkOutput({tag, " gnt port"}, {ifGnt[s], dGnt[s]}, {e.isIf, !e.isIf});
        checkOutput({tag, " mem_addr"}, memAddr[s], e.addr);
        checkOutput({tag, " rd/wr strobes"}, {memRead[s], memWrite[s]}, {e.rd, e.wr});
        checkOutput({tag, " mem_data_in"}, memDataIn[s], e.din);
        checkOutput({tag, " mem_byteen"}, memByteen[s], e.be);
      end
    end else begin
      checkOutput({tag, " idle strobes"}, {memRead[s], memWrite[s], memByteen[s]}, '0);
      checkOutput({tag, " idle addr/data"}, {memAddr[s], memDataIn[s]}, '0);
    end

    if (ifRvalid[s] || dRvalid[s]) begin
      idx = -1;
      foreach (rspQ[k]) if (idx < 0 && rspQ[k].dut == s && rspQ[k].cyc == cyc) idx = k;
      if (idx < 0) begin
        reportFail({tag, " unexpected rvalid"});
      end else begin
        r = rspQ[idx];
        rspQ.delete(idx);
        checkOutput({tag, " rvalid port"}, {ifRvalid[s], dRvalid[s]}, {r.isIf, !r.isIf});
        checkOutput({tag, " owner rdata"}, r.isIf ? ifRdata[s] : dRdata[s], r.data);
        checkOutput({tag, " other rdata"}, r.isIf ? dRdata[s] : ifRdata[s], '0);
      end
    end else begin
      checkOutput({tag, " idle rdata"}, {ifRdata[s], dRdata[s]}, '0);
    end
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) monitorDut(s);
  end

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int s, input bit ifR, input logic [31:0] ifA, input bit dR,
                               input bit we, input logic [31:0] dA, input logic [31:0] wd,
                               input logic [3:0] be);
    ifReq[s]   = ifR;
    ifAddr[s]  = ifA;
    dReq[s]    = dR;
    dWe[s]     = we;
    dAddr[s]   = dA;
    dWdata[s]  = wd;
    dByteen[s] = be;
  endtask

  task automatic pushIss(input int s, input int c, input bit isIf, input logic [31:0] a,
                         input bit rd, input bit wr, input logic [31:0] din, input logic [3:0] be);
    iss_t e;
    e.dut = s; e.cyc = c; e.isIf = isIf; e.addr = a; e.rd = rd; e.wr = wr; e.din = din; e.be = be;
    issQ.push_back(e);
  endtask

  task automatic pushRsp(input int s, input int c, input bit isIf, input logic [31:0] d);
    rsp_t r;
    r.dut = s; r.cyc = c; r.isIf = isIf; r.data = d;
    rspQ.push_back(r);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) applyStimulus(s, 0, '0, 0, 0, '0, '0, '0);

    // A request held during reset must not be granted.
    waitCycle();
    applyStimulus(0, 1, 32'h100, 0, 0, '0, '0, '0);
    #1;
    checkAllZero(0, "reset");
    checkAllZero(1, "reset");
    applyStimulus(0, 0, '0, 0, 0, '0, '0, '0);
    waitCycle();
    #2 rst_n = 1'b1;
    repeat (2) waitCycle();

    // A: single fetch, which returns a NOP.
    waitCycle();
    b = cyc;
    applyStimulus(0, 1, 32'h100, 0, 0, '0, '0, '0);
    pushIss(0, b, 1, 32'h100, 1, 0, '0, 4'hF);
    pushRsp(0, b + 1, 1, 32'h0000_0013);
    waitCycle();
    applyStimulus(0, 0, '0, 0, 0, '0, '0, '0);
    repeat (3) waitCycle();

    // A: simultaneous fetch and data read, where data wins first.
    waitCycle();
    b = cyc;
    applyStimulus(0, 1, 32'h104, 1, 0, 32'h2000, '0, '0);
    pushIss(0, b, 0, 32'h2000, 1, 0, '0, 4'hF);
    pushRsp(0, b + 1, 0, 32'hA5A5_2000);
    pushIss(0, b + 1, 1, 32'h104, 1, 0, '0, 4'hF);
    pushRsp(0, b + 2, 1, 32'hA5A5_0104);
    waitCycle();
    applyStimulus(0, 1, 32'h104, 0, 0, '0, '0, '0);
    waitCycle();
    applyStimulus(0, 0, '0, 0, 0, '0, '0, '0);
    repeat (3) waitCycle();

    // A: continuous contention, where fetch wins after four lost contentions.
    waitCycle();
    b = cyc;
    applyStimulus(0, 1, 32'h200, 1, 0, 32'h3000, '0, '0);
    for (int k = 0; k < 4; k++) begin
      pushIss(0, b + k, 0, 32'h3000, 1, 0, '0, 4'hF);
      pushRsp(0, b + k + 1, 0, 32'hA5A5_3000);
    end
    pushIss(0, b + 4, 1, 32'h200, 1, 0, '0, 4'hF);
    pushRsp(0, b + 5, 1, 32'hA5A5_0200);
    pushIss(0, b + 5, 0, 32'h3000, 1, 0, '0, 4'hF);
    pushRsp(0, b + 6, 0, 32'hA5A5_3000);
    repeat (5) waitCycle();
    applyStimulus(0, 0, '0, 1, 0, 32'h3000, '0, '0);
    waitCycle();
    applyStimulus(0, 0, '0, 0, 0, '0, '0, '0);
    repeat (3) waitCycle();

    // A: partial write, whose completion carries zero data.
    waitCycle();
    b = cyc;
    applyStimulus(0, 0, '0, 1, 1, 32'h2000, 32'hDEAD_BEEF, 4'b0011);
    pushIss(0, b, 0, 32'h2000, 0, 1, 32'hDEAD_BEEF, 4'b0011);
    pushRsp(0, b + 1, 0, 32'h0);
    waitCycle();
    applyStimulus(0, 0, '0, 0, 0, '0, '0, '0);
    repeat (3) waitCycle();

    // B: continuous fetch at latency 3.
    waitCycle();
    b = cyc;
    applyStimulus(1, 1, 32'h400, 0, 0, '0, '0, '0);
    pushIss(1, b, 1, 32'h400, 1, 0, '0, 4'hF);
    pushIss(1, b + 3, 1, 32'h404, 1, 0, '0, 4'hF);
    pushIss(1, b + 6, 1, 32'h408, 1, 0, '0, 4'hF);
    pushRsp(1, b + 3, 1, 32'hA5A5_0400);
    pushRsp(1, b + 6, 1, 32'hA5A5_0404);
    pushRsp(1, b + 9, 1, 32'hA5A5_0408);
    waitCycle();
    applyStimulus(1, 1, 32'h404, 0, 0, '0, '0, '0);
    repeat (3) waitCycle();
    applyStimulus(1, 1, 32'h408, 0, 0, '0, '0, '0);
    repeat (3) waitCycle();
    applyStimulus(1, 0, '0, 0, 0, '0, '0, '0);
    repeat (4) waitCycle();

    // B: reset mid-transaction drops the response, and the next grant waits for release.
    waitCycle();
    b = cyc;
    applyStimulus(1, 1, 32'h500, 0, 0, '0, '0, '0);
    pushIss(1, b, 1, 32'h500, 1, 0, '0, 4'hF);
    waitCycle();
    applyStimulus(1, 0, '0, 0, 0, '0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    checkAllZero(0, "async reset");
    checkAllZero(1, "async reset");
    applyStimulus(1, 1, 32'h504, 0, 0, '0, '0, '0);
    #1;
    checkAllZero(1, "reset with req");
    waitCycle();
    applyStimulus(1, 0, '0, 0, 0, '0, '0, '0);
    #2 rst_n = 1'b1;
    waitCycle();
    applyStimulus(1, 1, 32'h504, 0, 0, '0, '0, '0);
    pushIss(1, b + 3, 1, 32'h504, 1, 0, '0, 4'hF);
    pushRsp(1, b + 6, 1, 32'hA5A5_0504);
    waitCycle();
    applyStimulus(1, 0, '0, 0, 0, '0, '0, '0);
    repeat (6) waitCycle();

    checkOutput("issue queue drained", 64'(issQ.size()), 64'd0);
    checkOutput("response queue drained", 64'(rspQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
